// File: rtl/eth_tx_scheduler.sv
// Audio/image packet scheduler feeding eth_packer: arbitrates two byte sources,
// frames each grant as tag [+ 24-bit address] + payload and emits LSB-first dibits.
module eth_tx_scheduler #(
    parameter int          PIXELS_PER_PKT = 256,
    parameter int          AUDIO_PER_PKT  = 64,
    parameter int          GAP_CYCLES     = 48,
    parameter int          MAX_AUDIO_RUN  = 2,
    parameter logic [7:0]  AUDIO_TAG      = 8'hA0,
    parameter logic [7:0]  IMAGE_TAG      = 8'h1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_pkt_rdy,
    input  logic        audio_valid,
    input  logic [7:0]  audio_data,
    output logic        audio_ready,
    input  logic        pixel_pkt_rdy,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel_data,
    input  logic [23:0] pixel_addr,
    output logic        pixel_ready,
    input  logic        stall,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        busy,
    output logic        cur_is_audio,
    output logic        underrun
);

    localparam int MAX_PL = (PIXELS_PER_PKT > AUDIO_PER_PKT) ? PIXELS_PER_PKT : AUDIO_PER_PKT;
    localparam int BCNT_W = $clog2(MAX_PL + 5);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int RUN_W  = $clog2(MAX_AUDIO_RUN + 2);

    // Byte index of the final byte in the shift register (tag is index 0).
    localparam logic [BCNT_W-1:0] AUD_LAST = BCNT_W'(AUDIO_PER_PKT);
    localparam logic [BCNT_W-1:0] IMG_LAST = BCNT_W'(PIXELS_PER_PKT + 3);
    localparam logic [BCNT_W-1:0] ADDR_END = BCNT_W'(3);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_AUDIO_RUN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_ADDR,
        S_PAYLOAD,
        S_GAP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_shift;
    logic [1:0]          r_didx;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [GAP_W-1:0]    r_gap;
    logic [RUN_W-1:0]    r_run;
    logic [23:0]         r_addr;
    logic                r_cur_is_audio;
    logic                r_underrun;

    logic                w_active;
    logic                w_xfer;
    logic                w_byte_end;
    logic                w_last;
    logic [BCNT_W-1:0]   w_bcnt_nxt;
    logic                w_addr_phase;
    logic                w_pop;
    logic                w_src_valid;
    logic [7:0]          w_src_data;
    logic [7:0]          w_addr_byte;
    logic [7:0]          w_next_byte;
    logic                w_grant_a_pri;
    logic                w_grant_img;
    logic                w_grant_aud;
    logic                w_grant;

    assign w_active     = (r_state == S_TAG) || (r_state == S_ADDR) || (r_state == S_PAYLOAD);
    assign w_xfer       = w_active && !stall;
    assign w_byte_end   = w_xfer && (r_didx == 2'd3);
    assign w_last       = (r_bcnt == (r_cur_is_audio ? AUD_LAST : IMG_LAST));
    assign w_bcnt_nxt   = r_bcnt + 1'b1;
    assign w_addr_phase = !r_cur_is_audio && (w_bcnt_nxt <= ADDR_END);
    assign w_pop        = w_byte_end && !w_last && !w_addr_phase;

    assign w_src_valid  = r_cur_is_audio ? audio_valid : pixel_valid;
    assign w_src_data   = r_cur_is_audio ? audio_data  : pixel_data;

    always_comb begin
        w_addr_byte = r_addr[7:0];
        case (w_bcnt_nxt[1:0])
            2'd1:    w_addr_byte = r_addr[23:16];
            2'd2:    w_addr_byte = r_addr[15:8];
            default: w_addr_byte = r_addr[7:0];
        endcase
    end

    // A missing source byte is replaced by zero so the frame length never changes.
    assign w_next_byte = w_addr_phase ? w_addr_byte : (w_src_valid ? w_src_data : 8'h00);

    // Audio wins until it has taken MAX_AUDIO_RUN grants in a row while image waits.
    assign w_grant_a_pri = audio_pkt_rdy && (r_run < RUN_MAX);
    assign w_grant_img   = !w_grant_a_pri && pixel_pkt_rdy;
    assign w_grant_aud   = w_grant_a_pri || (!pixel_pkt_rdy && audio_pkt_rdy);
    assign w_grant       = w_grant_aud || w_grant_img;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant)
                    w_state_nxt = S_TAG;
            end
            S_TAG, S_ADDR, S_PAYLOAD: begin
                if (w_byte_end) begin
                    if (w_last)
                        w_state_nxt = S_GAP;
                    else if (w_addr_phase)
                        w_state_nxt = S_ADDR;
                    else
                        w_state_nxt = S_PAYLOAD;
                end
            end
            S_GAP: begin
                if (r_gap == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift        <= '0;
            r_didx         <= '0;
            r_bcnt         <= '0;
            r_gap          <= '0;
            r_run          <= '0;
            r_addr         <= '0;
            r_cur_is_audio <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!pixel_pkt_rdy || w_grant_img)
                        r_run <= '0;
                    else if (w_grant_aud && (r_run != RUN_MAX))
                        r_run <= r_run + 1'b1;
                    if (w_grant) begin
                        r_cur_is_audio <= w_grant_aud;
                        r_shift        <= w_grant_aud ? AUDIO_TAG : IMAGE_TAG;
                        r_didx         <= '0;
                        r_bcnt         <= '0;
                        if (w_grant_img)
                            r_addr <= pixel_addr;
                    end
                end
                S_TAG, S_ADDR, S_PAYLOAD: begin
                    if (w_byte_end) begin
                        r_didx <= '0;
                        if (w_last) begin
                            r_gap <= GAP_LOAD;
                        end else begin
                            r_shift <= w_next_byte;
                            r_bcnt  <= w_bcnt_nxt;
                        end
                        if (w_pop && !w_src_valid)
                            r_underrun <= 1'b1;
                    end else if (w_xfer) begin
                        r_didx <= r_didx + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap != '0)
                        r_gap <= r_gap - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign axiov        = w_active;
    assign axiod        = w_active ? r_shift[{r_didx, 1'b0} +: 2] : 2'b00;
    assign audio_ready  = w_pop && r_cur_is_audio;
    assign pixel_ready  = w_pop && !r_cur_is_audio;
    assign busy         = (r_state != S_IDLE);
    assign cur_is_audio = r_cur_is_audio;
    assign underrun     = r_underrun;

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
Sole feeder of eth_packer. Arbitrates between an audio byte source and an image (pixel) byte source, frames each grant as one tagged packet (type byte, optional 24-bit pixel address, fixed-length payload) and serialises it as RMII-order dibits. Honours eth_packer's stall. Guarantees inter-packet gaps so eth_packer closes each frame. Sits where reverse_bit_order drives eth_packer today; the receive-side image_audio_splitter decodes the same tags.

Parameters:
PIXELS_PER_PKT, 256, payload bytes per image packet (>=1)
AUDIO_PER_PKT, 64, payload bytes per audio packet (>=1)
GAP_CYCLES, 48, cycles axiov held low between packets (>=1)
MAX_AUDIO_RUN, 2, consecutive audio grants allowed while image is pending
AUDIO_TAG, 8'hA0, type byte for audio packets
IMAGE_TAG, 8'h1F, type byte for image packets

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
audio_pkt_rdy  in  1  audio source holds >= AUDIO_PER_PKT bytes
audio_valid  in  1  audio_data valid
audio_data  in  8  audio byte
audio_ready  out  1  one-cycle pop strobe for audio byte
pixel_pkt_rdy  in  1  image source holds >= PIXELS_PER_PKT bytes
pixel_valid  in  1  pixel_data valid
pixel_data  in  8  pixel byte
pixel_addr  in  24  address of first pixel of next packet; stable while pixel_pkt_rdy
pixel_ready  out  1  one-cycle pop strobe for pixel byte
stall  in  1  from eth_packer; high = dibit not accepted
axiov  out  1  dibit valid to eth_packer
axiod  out  2  dibit to eth_packer
busy  out  1  high in any state except IDLE
cur_is_audio  out  1  type of packet in flight (valid while busy)
underrun  out  1  sticky; set when a source byte is missing at pop time

Behaviour:
- Reset: axiov=0, axiod=2'b00, audio_ready=0, pixel_ready=0, busy=0, cur_is_audio=0, underrun=0, audio run counter=0, state=IDLE. Reset asserted mid-packet: all outputs take reset values on that edge. Packet is truncated; no resume.
- States: IDLE -> TAG -> ADDR (image only, 3 bytes) -> PAYLOAD -> GAP -> IDLE.
- IDLE arbitration, evaluated every cycle:
  - audio_pkt_rdy and run<MAX_AUDIO_RUN -> grant audio.
  - else pixel_pkt_rdy -> grant image.
  - else audio_pkt_rdy -> grant audio.
  - Audio grant increments run (saturating). Image grant clears run. run also clears whenever pixel_pkt_rdy=0 in IDLE.
- Grant effects:
  - latch cur_is_audio; for image, latch pixel_addr.
  - load shift register with the tag; enter TAG.
  - axiov=1 from the next cycle, with the first dibit.
- Serialisation:
  - Each byte is sent as 4 dibits, LSB first: bits[1:0], [3:2], [5:4], [7:6].
  - A dibit transfers on a cycle with axiov=1 and stall=0. stall=1 holds axiod, the dibit index and all state; axiov stays 1.
  - axiov is continuous from first to last dibit of a packet.
- Byte loading: on the transfer of dibit 3 of a byte, the next byte is loaded in the same edge.
  - ADDR: pixel_addr[23:16], then [15:8], then [7:0].
  - PAYLOAD: *_ready is asserted combinationally for exactly that cycle, and the byte is *_data.
  - *_ready is never asserted while stall=1 or outside PAYLOAD loads.
- Underrun: *_valid=0 at pop time -> load 8'h00, set underrun, continue. Packet length is never changed.
- Packet length in dibits: audio = 4*(1+AUDIO_PER_PKT); image = 4*(4+PIXELS_PER_PKT). Byte counter is sized for max(param)+4.
- After the last payload dibit transfers: axiov=0, axiod=0 next cycle. GAP lasts exactly GAP_CYCLES cycles (stall ignored), then IDLE. Earliest next axiov is GAP_CYCLES+2 cycles after the last transfer.
- pkt_rdy changes during a packet are ignored until IDLE.

Test Plan:
- AUDIO_PER_PKT=4; audio_pkt_rdy=1, bytes 11,22,33,44; stall=0.
  -> axiod: 00,00,10,10 (A0), 01,00,01,00 (11), …; 20 contiguous axiov cycles; exactly 4 audio_ready pulses; axiov low for GAP_CYCLES.
- PIXELS_PER_PKT=2; pixel_addr=24'h012345; bytes C0,AA.
  -> byte sequence 1F,01,23,45,C0,AA; 24 dibits; pixel_ready pulses only on the last two byte loads.
- Both pkt_rdy held high, MAX_AUDIO_RUN=2.
  -> grant order audio, audio, image, audio, audio, image; audio is first when both rise in the same cycle.
- stall high 5 cycles after dibit 2 of payload byte 33.
  -> axiod frozen; no *_ready during stall; resumes with dibit 3; total transfers still 20.
- pixel_valid=0 at the 2nd payload pop.
  -> byte 00 emitted; underrun=1 and stays 1; packet length unchanged; cleared only by rst.
- rst pulse mid-PAYLOAD.
  -> next edge: axiov=0, busy=0, underrun=0; a new grant begins with the tag byte.
